// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit/receive pair.
//   uart_tx_state_t : transmitter frame state
//   ticks_per_bit() : clock cycles per line bit, shared with uart_rx
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    function automatic int ticks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data.
//   clock, reset   : clock, synchronous active-high reset (flushes contents)
//   push/push_data : write request; ignored while full
//   pop/pop_data   : read request; pop_data is the head word, valid while !empty
//   full/empty     : occupancy flags
//   count          : words held, one extra bit so full and empty differ
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/buff_uart_tx.sv
// buff_uart_tx: buffered UART transmitter, 1 start bit, WIDTH data bits LSB first, 1 stop bit.
//   clock, reset          : clock, synchronous active-high reset (aborts any frame)
//   data/data_valid       : producer word and its valid
//   data_ready            : FIFO has room; a word transfers when data_valid && data_ready
//   signal                : registered TX line, idle high
//   busy                  : frame in progress or words still queued
//   fifo_count            : words waiting in the FIFO (excludes the word being shifted)
module buff_uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          signal,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TPB = ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int TW  = $clog2(TPB);
    localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TPB - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    uart_tx_state_t   state;
    uart_tx_state_t   next_state;
    logic [TW-1:0]    tick;
    logic [BW-1:0]    bit_count;
    logic [WIDTH-1:0] shift;
    logic             line_c;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             bit_end;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (data_valid),
        .push_data (data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign data_ready = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign bit_end    = (tick == '0);

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        line_c     = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                line_c = 1'b0;
                if (bit_end) next_state = DATA;
            end
            DATA: begin
                line_c = shift[0];
                if (bit_end && bit_count == BIT_LAST) next_state = STOP;
            end
            STOP: begin
                // Chain straight into the next frame so queued words go out gap-free.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The line is registered from the current state, so it trails the state by one
    // cycle; every bit still lasts exactly TPB cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            bit_count <= '0;
            shift     <= '0;
            signal    <= 1'b1;
        end else begin
            state  <= next_state;
            signal <= line_c;

            if (next_state != state || (state == DATA && bit_end)) begin
                tick <= TICK_MAX;
            end else if (state != IDLE) begin
                tick <= tick - TW'(1);
            end

            if (pop) begin
                shift     <= fifo_head;
                bit_count <= '0;
            end else if (state == DATA && bit_end) begin
                shift     <= shift >> 1;
                bit_count <= bit_count + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_buff_uart_tx.sv
module tb_buff_uart_tx;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int TPB = 8;
    localparam int FB  = (W + 2) * TPB;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data = '0;
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic         signal;
    logic         busy;
    logic [2:0]   fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_q[$];
    int           start_q[$];

    buff_uart_tx #(
        .CLOCK_FREQ (8),
        .BAUD_RATE  (1),
        .WIDTH      (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .signal     (signal),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Model receiver: samples mid-bit on the falling clock edge, aborted by reset.
    bit           rx_on = 1'b0;
    int           rx_t  = 0;
    logic [W-1:0] rx_sh = '0;
    always @(negedge clock) begin
        if (reset) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (signal === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
                start_q.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t == TPB / 2) begin
                chk("start_bit", signal, 1'b0);
            end else if (rx_t == TPB / 2 + (W + 1) * TPB) begin
                chk("stop_bit", signal, 1'b1);
                rx_q.push_back(rx_sh);
                rx_on = 1'b0;
            end else if (rx_t > TPB / 2 && (rx_t - TPB / 2) % TPB == 0) begin
                rx_sh = {signal, rx_sh[W-1:1]};
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        int g;
        data       = w;
        data_valid = 1'b1;
        g = 0;
        while (!data_ready && g < 500) begin
            step();
            g++;
        end
        if (g >= 500) chk("push_timeout", 32'd0, 32'd1);
        step();
        exp_q.push_back(w);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 5000) begin
            step();
            g++;
        end
        chk("idle_timeout", 32'(g < 5000), 32'd1);
        step(TPB);
    endtask

    task automatic cmp_rx(input string tag);
        int n;
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_word"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
        start_q.delete();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W+1:0] frame;
        logic [W-1:0] w;
        int           n_acc;
        int           g;

        // 1. reset and idle
        step(3);
        chk("reset_outs", {signal, busy, data_ready, fifo_count}, {1'b1, 1'b0, 1'b1, 3'd0});
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_outs", {signal, busy, data_ready, fifo_count}, {1'b1, 1'b0, 1'b1, 3'd0});
        end

        // 2. single frame, latency and bit timing
        push(8'hA5);
        chk("lat_edge_n", signal, 1'b1);
        step();
        chk("lat_edge_n1", signal, 1'b1);
        step();
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < FB; k++) begin
            chk("a5_line", signal, frame[k / TPB]);
            if (k == FB - 2) chk("a5_busy_end", busy, 1'b1);
            if (k == FB - 1) chk("a5_idle_after", busy, 1'b0);
            step();
        end
        step(TPB);
        cmp_rx("a5");

        // 3. back-to-back frames
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        push(8'hC3);
        wait_idle();
        chk("b2b_frames", start_q.size(), 4);
        for (int i = 1; i < start_q.size(); i++) chk("b2b_gap", start_q[i] - start_q[i-1], FB);
        cmp_rx("b2b");

        // 4. hold data_valid until the FIFO fills
        n_acc = 0;
        data_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data = W'(8'h40 + i);
            if (data_ready) begin
                exp_q.push_back(data);
                n_acc++;
            end
            step();
        end
        data_valid = 1'b0;
        chk("fill_accepted", n_acc, 5);
        chk("fill_ready", data_ready, 1'b0);
        chk("fill_count", fifo_count, 3'd4);
        g = 0;
        while (fifo_count == 3'd4 && g < 200) begin
            step();
            g++;
        end
        chk("fill_pop_count", fifo_count, 3'd3);
        chk("fill_pop_ready", data_ready, 1'b1);
        wait_idle();
        cmp_rx("fill");

        // 5. reset mid-frame with words queued
        push(8'h5A);
        push(W'($urandom));
        push(W'($urandom));
        step(40);
        chk("mid_queued", fifo_count, 3'd2);
        reset = 1'b1;
        step();
        chk("abort_outs", {signal, busy, data_ready, fifo_count}, {1'b1, 1'b0, 1'b1, 3'd0});
        reset = 1'b0;
        exp_q.delete();
        rx_q.delete();
        start_q.delete();
        step(2);
        push(W'($urandom));
        wait_idle();
        cmp_rx("post_reset");

        // 6. push coinciding with STOP->START pop at count 2
        push(8'h11);
        push(8'h22);
        push(8'h33);
        step(FB - 2);
        chk("pp_before", fifo_count, 3'd2);
        push(8'h44);
        chk("pp_after", fifo_count, 3'd2);
        wait_idle();
        cmp_rx("pushpop");

        // 7. random words with random gaps
        for (int i = 0; i < 16; i++) begin
            step($urandom_range(0, 30));
            push(W'($urandom));
        end
        wait_idle();
        cmp_rx("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
